m_cycleacc: RTL and testbench
=============================

# m_cycleacc

Consumer end of the per-instruction cycle timer. Each time an instruction retires, it takes the 6-bit cycle count of that instruction and adds it into a 64-bit free-running cycle register (mcycle/ttime). It exposes that register as two 32-bit words on a small Wishbone-style slave port, with a coherent hi/lo snapshot. It sits beside the core's CSR/IO decode and replaces the in-ALU ttime addition where area permits.

## Interface
Parameters:
- `CCW`, 6: width of the per-instruction cycle count input.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `corerunning`  in  1  accumulation is enabled only while high.
- `ccnt_valid`  in  1  one-cycle pulse at an instruction boundary.
- `ccnt`  in  CCW  cycle count of the instruction just finished; sampled when `ccnt_valid` is high.
- `STB_I`  in  1  bus strobe; held high until `ACK_O`.
- `WE_I`  in  1  1 = write, 0 = read; sampled with `STB_I`.
- `ADR_I`  in  2  word select, equal to address bits [3:2].
- `DAT_I`  in  32  write data.
- `DAT_O`  out  32  read data; valid only while `ACK_O` is high.
- `ACK_O`  out  1  single-cycle acknowledge.
- `cmp_irq`  out  1  compare interrupt; exists only with the macro, otherwise tied to 0.

## Operation
- State:
  - `lo[31:0]` and `hi[31:0]`.
  - `cy`: pending carry from lo into hi.
  - `shadow[31:0]`: hi-word snapshot.
  - `ack`: ACK_O register.
  - Compare registers when the macro is enabled.
- Reset values: lo = hi = shadow = 0, cy = 0, `ACK_O` = 0, `DAT_O` = 0, `cmp_irq` = 0, cmp = all ones.
- Accumulate: when `corerunning & ccnt_valid`, set `{cy,lo} <= lo + zero-extended ccnt`. When `cy` = 1, the following cycle sets `hi <= hi + 1` and `cy <= 0`. A new accumulate may happen in the same cycle as the hi increment.
- `ccnt` = 0 is a valid input and adds 0. A 64-bit wrap goes to 0 with no flag.
- Bus states: IDLE → ACK → IDLE.
  - In IDLE with `STB_I` high, the transfer executes and `ACK_O` is asserted on the next cycle for exactly one cycle.
  - A request that is still high in the ACK cycle is ignored. Back-to-back transfers therefore have at least one idle cycle between acknowledges.
- Address map: 00 = lo, 01 = hi (shadow on read), 10 = cmp lo, 11 = cmp hi. Without the macro, addresses 10 and 11 read 0 and ignore writes.
- Read of lo: returns lo. In the same cycle, `shadow` is loaded with `hi + cy`, so the pair is coherent even while a carry is pending.
- Read of hi: returns `shadow`, not live hi.
- Write of lo: `lo <= DAT_I` and `cy <= 0`. An accumulate in the same cycle is dropped; the write wins.
- Write of hi: `hi <= DAT_I`. A pending carry in the same cycle is discarded.

## Timing
- `ccnt_valid` in cycle N: lo updated at edge N+1. On carry, hi updated at edge N+2.
- A read sampled in cycle N reflects state before edge N+1, including an accumulate from cycle N−1. `ACK_O` and `DAT_O` appear in cycle N+1.
- Write sampled in cycle N: the register holds the new value from edge N+1, and `ACK_O` is high in cycle N+1.
- Reset asserted mid-transfer: `ACK_O` drops immediately (asynchronously) and the transfer is lost. The master must re-issue it.
- `corerunning` low: `ccnt_valid` is ignored, but a pending carry still completes.

## Configuration
- `M_CYCLEACC_COMPARE_EN` defined:
  - Adds a 64-bit cmp register at words 10 and 11.
  - `cmp_irq` is registered and set when `{hi,lo} >= cmp`; the compare uses the live value, with cy folded in.
  - `cmp_irq` is cleared one cycle after any write to cmp that makes the compare false.
  - A write to cmp lo also sets cmp hi to all ones, giving a glitch-free 32-bit update sequence.
- Not defined: no cmp storage, `cmp_irq` is constant 0, and words 10 and 11 read 0.

## Test plan
- Reset, then read lo and hi: both return 0. `ACK_O` pulses once per read, one cycle after `STB_I`.
- `corerunning` = 1 with three pulses of ccnt = 5, 41, 0 → lo = 46, hi = 0. The same pulses with `corerunning` = 0 leave lo = 0.
- Write lo = 0xFFFFFFF0, then ccnt = 0x20 → lo = 0x10 one cycle later and hi = 1 two cycles later. A lo read issued in the carry-pending cycle returns 0x10, and the following hi read returns 1.
- Write hi = 0xFFFFFFFF and lo = 0xFFFFFFFF, then ccnt = 1 → lo = 0, hi = 0, no flag.
- Write lo = 7 in the same cycle as ccnt_valid with ccnt = 9 → lo = 7.
- With `M_CYCLEACC_COMPARE_EN`: cmp = 0x0000_0000_0000_0064, accumulate 50 + 50 → `cmp_irq` rises. Writing cmp lo = 0x200 then cmp hi = 0 → `cmp_irq` falls.

Source files
------------

// File: rtl/m_cycleacc.sv
// m_cycleacc: accumulates retired-instruction cycle counts into a 64-bit
// cycle register (lo/hi with a deferred carry) and exposes it on a small
// Wishbone-style slave with a coherent hi/lo snapshot.
// Optional compare/interrupt logic is built when M_CYCLEACC_COMPARE_EN is defined.
module m_cycleacc #(
    parameter int unsigned CCW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            corerunning,
    input  logic            ccnt_valid,
    input  logic [CCW-1:0]  ccnt,
    input  logic            STB_I,
    input  logic            WE_I,
    input  logic [1:0]      ADR_I,
    input  logic [31:0]     DAT_I,
    output logic [31:0]     DAT_O,
    output logic            ACK_O,
    output logic            cmp_irq
);

    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW + 1;
    localparam logic [1:0]  A_LO    = 2'b00;
    localparam logic [1:0]  A_HI    = 2'b01;
    localparam logic [1:0]  A_CMPLO = 2'b10;
    localparam logic [1:0]  A_CMPHI = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_e;

    bus_state_e        state_q, state_d;
    logic [DW-1:0]     lo_q, lo_d;
    logic [DW-1:0]     hi_q, hi_d;
    logic              cy_q, cy_d;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SW-1:0]     sum_c;
    logic              xfer_c, wr_c, rd_c;

`ifdef M_CYCLEACC_COMPARE_EN
    logic [2*DW-1:0]   cmp_q, cmp_d;
    logic [2*DW-1:0]   live_c;
    logic              irq_q, irq_d;
`endif

    // A transfer executes only when a strobe arrives in IDLE.
    assign xfer_c = (state_q == S_IDLE) && STB_I;
    assign wr_c   = xfer_c && WE_I;
    assign rd_c   = xfer_c && !WE_I;

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Bus FSM next state: one ACK cycle per accepted request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (STB_I) state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
        endcase
    end

    // Counter, carry, snapshot and read-data next state.
    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        cy_d     = cy_q;
        shadow_d = shadow_q;
        dat_d    = '0;
        sum_c    = SW'(lo_q) + SW'(ccnt);

        if (cy_q) begin
            hi_d = hi_q + DW'(1);
            cy_d = 1'b0;
        end
        if (corerunning && ccnt_valid) begin
            lo_d = sum_c[DW-1:0];
            cy_d = sum_c[DW];
        end

        if (wr_c) begin
            case (ADR_I)
                A_LO: begin
                    lo_d = DAT_I;
                    cy_d = 1'b0;
                end
                A_HI:    hi_d = DAT_I;
                default: ;
            endcase
        end

        if (rd_c) begin
            case (ADR_I)
                A_LO: begin
                    dat_d    = lo_q;
                    shadow_d = hi_q + DW'(cy_q);
                end
                A_HI:    dat_d = shadow_q;
`ifdef M_CYCLEACC_COMPARE_EN
                A_CMPLO: dat_d = cmp_q[DW-1:0];
                A_CMPHI: dat_d = cmp_q[2*DW-1:DW];
`endif
                default: dat_d = '0;
            endcase
        end
    end

    // Counter and bus output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q     <= '0;
            hi_q     <= '0;
            cy_q     <= 1'b0;
            shadow_q <= '0;
            dat_q    <= '0;
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cy_q     <= cy_d;
            shadow_q <= shadow_d;
            dat_q    <= dat_d;
        end
    end

    assign DAT_O = dat_q;
    assign ACK_O = (state_q == S_ACK);

`ifdef M_CYCLEACC_COMPARE_EN
    // Compare register writes and live compare with pending carry folded in.
    always_comb begin
        cmp_d = cmp_q;
        if (wr_c && (ADR_I == A_CMPLO)) begin
            cmp_d[DW-1:0]    = DAT_I;
            cmp_d[2*DW-1:DW] = '1;
        end
        if (wr_c && (ADR_I == A_CMPHI)) cmp_d[2*DW-1:DW] = DAT_I;
        live_c = {hi_q + DW'(cy_q), lo_q};
        irq_d  = (live_c >= cmp_q);
    end

    // Compare and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp_irq = irq_q;
`else
    assign cmp_irq = 1'b0;
`endif

endmodule

// File: tb/tb_m_cycleacc.sv
// Directed + randomized bench for m_cycleacc; the reference model holds the
// 64-bit cycle value as a plain number with the carry already folded in.
module tb_m_cycleacc;

    logic        clk;
    logic        rst_n;
    logic        corerunning;
    logic        ccnt_valid;
    logic [5:0]  ccnt;
    logic        STB_I;
    logic        WE_I;
    logic [1:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        cmp_irq;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [63:0] mdl;
    logic [31:0] shadow_m;
    logic [63:0] cmp_m;

    m_cycleacc #(.CCW(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .corerunning (corerunning),
        .ccnt_valid  (ccnt_valid),
        .ccnt        (ccnt),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ADR_I       (ADR_I),
        .DAT_I       (DAT_I),
        .DAT_O       (DAT_O),
        .ACK_O       (ACK_O),
        .cmp_irq     (cmp_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd);
        STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
        @(posedge clk); #1;
        chk("ack_pulse", 64'(ACK_O), 64'd1);
        rd = DAT_O;
        @(negedge clk);
        STB_I = 1'b0; WE_I = 1'b0;
        @(posedge clk); #1;
        chk("ack_single", 64'(ACK_O), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_pulse(input logic [5:0] c);
        ccnt_valid = 1'b1; ccnt = c;
        if (corerunning) mdl = mdl + 64'(c);
        @(negedge clk);
        ccnt_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] adr, input logic [31:0] d);
        logic [31:0] rd;
        bus(1'b1, adr, d, rd);
        case (adr)
            2'd0: mdl[31:0]  = d;
            2'd1: mdl[63:32] = d;
            2'd2: cmp_m      = {32'hFFFF_FFFF, d};
            default: cmp_m[63:32] = d;
        endcase
    endtask

    task automatic do_read(input string tag, input logic [1:0] adr);
        logic [31:0] rd;
        logic [31:0] exp;
        bus(1'b0, adr, 32'h0, rd);
        case (adr)
            2'd0: begin exp = mdl[31:0]; shadow_m = mdl[63:32]; end
            2'd1: exp = shadow_m;
`ifdef M_CYCLEACC_COMPARE_EN
            2'd2: exp = cmp_m[31:0];
            default: exp = cmp_m[63:32];
`else
            default: exp = 32'h0;
`endif
        endcase
        chk(tag, 64'(rd), 64'(exp));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  a;
        int unsigned op;

        rst_n = 1'b0; corerunning = 1'b0; ccnt_valid = 1'b0; ccnt = '0;
        STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
        mdl = '0; shadow_m = '0; cmp_m = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", 64'(ACK_O), 64'd0);
        chk("rst_dat", 64'(DAT_O), 64'd0);
        chk("rst_irq", 64'(cmp_irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_read("rst_lo", 2'd0);
        do_read("rst_hi", 2'd1);

        // Accumulate with the core running, then with it stopped.
        corerunning = 1'b1;
        do_pulse(6'd5); do_pulse(6'd41); do_pulse(6'd0);
        do_read("acc_lo46", 2'd0);
        do_read("acc_hi0", 2'd1);
        do_write(2'd0, 32'h0);
        corerunning = 1'b0;
        do_pulse(6'd5); do_pulse(6'd41); do_pulse(6'd0);
        do_read("stopped_lo", 2'd0);

        // Carry into hi, with the lo read landing in the carry-pending cycle.
        corerunning = 1'b1;
        do_write(2'd0, 32'hFFFF_FFF0);
        do_pulse(6'h20);
        do_read("carry_lo", 2'd0);
        do_read("carry_hi", 2'd1);

        // 64-bit wrap to zero.
        do_write(2'd1, 32'hFFFF_FFFF);
        do_write(2'd0, 32'hFFFF_FFFF);
        do_pulse(6'd1);
        do_read("wrap_lo", 2'd0);
        do_read("wrap_hi", 2'd1);

        // Write of lo beats a same-cycle accumulate.
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; DAT_I = 32'd7;
        ccnt_valid = 1'b1; ccnt = 6'd9;
        @(posedge clk); #1;
        chk("wr_acc_ack", 64'(ACK_O), 64'd1);
        @(negedge clk);
        STB_I = 1'b0; WE_I = 1'b0; ccnt_valid = 1'b0;
        mdl[31:0] = 32'd7;
        @(negedge clk);
        do_read("wr_wins_lo", 2'd0);

        // A strobe still high during the ACK cycle is not a new request.
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd0;
        @(posedge clk); #1;
        chk("held_ack1", 64'(ACK_O), 64'd1);
        chk("held_dat", 64'(DAT_O), 64'(mdl[31:0]));
        shadow_m = mdl[63:32];
        @(posedge clk); #1;
        chk("held_ignored", 64'(ACK_O), 64'd0);
        @(negedge clk);
        STB_I = 1'b0;
        @(posedge clk); #1;
        chk("held_quiet", 64'(ACK_O), 64'd0);
        @(negedge clk);

        // Unmapped/compare words.
        do_write(2'd2, 32'h1234_5678);
        do_read("cmp_lo_rd", 2'd2);
        do_read("cmp_hi_rd", 2'd3);

        // Randomized mix of accumulates, writes and reads.
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1, 2: begin
                    corerunning = ($urandom_range(0, 3) != 0);
                    do_pulse(6'($urandom_range(0, 63)));
                end
                3: begin
                    d = $urandom;
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFC0 | (d & 32'h3F);
                    do_write(2'd0, d);
                end
                4: do_write(2'd1, $urandom);
                5: begin
                    do_read("rnd_lo", 2'd0);
                    do_read("rnd_hi", 2'd1);
                end
                default: begin
                    a = 2'($urandom_range(2, 3));
                    do_write(a, $urandom);
                    do_read("rnd_cmp", a);
                end
            endcase
        end
        corerunning = 1'b1;
        do_read("end_lo", 2'd0);
        do_read("end_hi", 2'd1);

        // Reset during the ACK cycle drops ACK_O immediately.
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd0;
        @(posedge clk); #1;
        chk("mid_ack", 64'(ACK_O), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(ACK_O), 64'd0);
        chk("mid_rst_dat", 64'(DAT_O), 64'd0);
        @(negedge clk);
        STB_I = 1'b0;
        rst_n = 1'b1;
        mdl = '0; shadow_m = '0; cmp_m = '1;
        @(negedge clk);
        do_read("post_rst_lo", 2'd0);
        do_read("post_rst_hi", 2'd1);

`ifdef M_CYCLEACC_COMPARE_EN
        // Compare interrupt rises on reaching cmp and falls after cmp moves up.
        do_write(2'd2, 32'h64);
        do_read("cmp_hi_ones", 2'd3);
        do_write(2'd3, 32'h0);
        repeat (2) @(negedge clk);
        chk("irq_below", 64'(cmp_irq), 64'd0);
        corerunning = 1'b1;
        do_pulse(6'd50);
        do_pulse(6'd50);
        repeat (2) @(negedge clk);
        chk("irq_rise", 64'(cmp_irq), 64'd1);
        do_write(2'd2, 32'h200);
        chk("irq_fall", 64'(cmp_irq), 64'd0);
        do_write(2'd3, 32'h0);
        repeat (2) @(negedge clk);
        chk("irq_stay_low", 64'(cmp_irq), 64'd0);
`else
        corerunning = 1'b1;
        do_pulse(6'd63);
        do_write(2'd3, 32'h0);
        repeat (2) @(negedge clk);
        chk("irq_tied", 64'(cmp_irq), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
